// File: rtl/cam_boot_monitor_pkg.sv
// Shared camera definitions: FSM state encodings and default timing constants,
// common to the boot monitor and the power-up sequencer.
package cam_boot_monitor_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_FIRST = 3'd0,
    ST_MEASURE    = 3'd1,
    ST_READY      = 3'd2,
    ST_RETRY      = 3'd3,
    ST_FAIL       = 3'd4
  } cam_state_e;

  localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd8_000_000;
  localparam logic [23:0] DEF_PERIOD_TOL     = 24'd4096;

  function automatic logic [23:0] abs_diff(input logic [23:0] a, input logic [23:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/cam_boot_monitor_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse is high for one clk, three clks after the asynchronous input rises.
module sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      prev  <= sync;
      pulse <= sync & ~prev;
    end
  end

endmodule

// File: rtl/cam_boot_monitor.sv
// Camera boot monitor: declares the sensor alive once VSYNC arrives at a stable
// period, and requests bounded sensor-reset retries on silence.
module cam_boot_monitor
  import cam_boot_monitor_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_FRAMES  = 4,
  parameter logic [23:0] PERIOD_TOL     = DEF_PERIOD_TOL,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cam_vsync,
  output logic        cam_ready,
  output logic        cam_rst_req,
  output logic        cam_fail,
  output logic [23:0] frame_period,
  output logic [1:0]  retry_cnt,
  output logic [2:0]  state_o
);

  localparam logic [3:0] STABLE_TGT = STABLE_FRAMES[3:0];
  localparam logic [1:0] RETRY_MAX  = MAX_RETRIES[1:0];

  cam_state_e  state;
  logic        vs_edge;
  logic [23:0] timer;
  logic [23:0] ref_period;
  logic        have_ref;
  logic [3:0]  stable_cnt;

  logic        timeout;
  logic [23:0] period;
  logic        in_tol;
  logic [3:0]  stable_next;
  logic [23:0] timer_next;

  sync_edge u_vsync_edge (
    .clk    (clk),
    .resetn (resetn),
    .din    (cam_vsync),
    .pulse  (vs_edge)
  );

  always_comb begin
    timeout     = (timer == TIMEOUT_CYCLES);
    period      = timer + 24'd1;
    in_tol      = (abs_diff(period, ref_period) <= PERIOD_TOL);
    stable_next = stable_cnt + 4'd1;
    timer_next  = timeout ? timer : (timer + 24'd1);
  end

  assign state_o = state;

  // Entry into RETRY already knows whether a request is due, so the pulse
  // lines up with the single RETRY clk; retry_cnt advances when it leaves.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_WAIT_FIRST;
      timer        <= '0;
      ref_period   <= '0;
      have_ref     <= 1'b0;
      stable_cnt   <= '0;
      cam_ready    <= 1'b0;
      cam_rst_req  <= 1'b0;
      cam_fail     <= 1'b0;
      frame_period <= '0;
      retry_cnt    <= '0;
    end else begin
      cam_rst_req <= 1'b0;
      timer       <= timer_next;
      case (state)
        ST_WAIT_FIRST: begin
          if (vs_edge) begin
            state      <= ST_MEASURE;
            timer      <= '0;
            have_ref   <= 1'b0;
            stable_cnt <= '0;
          end else if (timeout) begin
            state       <= ST_RETRY;
            timer       <= '0;
            cam_rst_req <= (retry_cnt != RETRY_MAX);
          end
        end
        ST_MEASURE: begin
          if (vs_edge) begin
            timer      <= '0;
            ref_period <= period;
            if (!have_ref) begin
              have_ref <= 1'b1;
            end else if (in_tol) begin
              frame_period <= period;
              stable_cnt   <= stable_next;
              if (stable_next == STABLE_TGT) begin
                state     <= ST_READY;
                cam_ready <= 1'b1;
              end
            end else begin
              stable_cnt <= '0;
            end
          end else if (timeout) begin
            state       <= ST_RETRY;
            timer       <= '0;
            cam_rst_req <= (retry_cnt != RETRY_MAX);
          end
        end
        ST_READY: begin
          if (vs_edge) begin
            timer      <= '0;
            ref_period <= period;
            if (in_tol) begin
              frame_period <= period;
            end else begin
              state      <= ST_MEASURE;
              cam_ready  <= 1'b0;
              stable_cnt <= '0;
              have_ref   <= 1'b1;
            end
          end else if (timeout) begin
            state       <= ST_RETRY;
            timer       <= '0;
            cam_ready   <= 1'b0;
            cam_rst_req <= (retry_cnt != RETRY_MAX);
          end
        end
        ST_RETRY: begin
          timer <= '0;
          if (retry_cnt == RETRY_MAX) begin
            state    <= ST_FAIL;
            cam_fail <= 1'b1;
          end else begin
            retry_cnt <= retry_cnt + 2'd1;
            state     <= ST_WAIT_FIRST;
          end
        end
        ST_FAIL: begin
          timer     <= timer;
          cam_fail  <= 1'b1;
          cam_ready <= 1'b0;
        end
        default: begin
          state <= ST_WAIT_FIRST;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_boot_monitor.sv
// Directed bench for cam_boot_monitor with short timing parameters
// (timeout 1000 clks, 4 stable frames, tolerance 4, 3 retries).
module tb_cam_boot_monitor;

  logic        clk;
  logic        resetn;
  logic        cam_vsync;
  logic        cam_ready;
  logic        cam_rst_req;
  logic        cam_fail;
  logic [23:0] frame_period;
  logic [1:0]  retry_cnt;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int req_cycles[$];

  cam_boot_monitor #(
    .TIMEOUT_CYCLES (24'd1000),
    .STABLE_FRAMES  (4),
    .PERIOD_TOL     (24'd4),
    .MAX_RETRIES    (3)
  ) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .cam_vsync    (cam_vsync),
    .cam_ready    (cam_ready),
    .cam_rst_req  (cam_rst_req),
    .cam_fail     (cam_fail),
    .frame_period (frame_period),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cam_rst_req === 1'b1) req_cycles.push_back(cyc);

  task automatic do_reset();
    resetn    = 1'b0;
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    base   = cyc;
  endtask

  // n rises, each followed by enough idle clks that the next rise is 'period' clks later
  task automatic vsync_frames(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cam_vsync = 1'b1;
      repeat (4) @(negedge clk);
      cam_vsync = 1'b0;
      repeat (period - 5) @(negedge clk);
    end
  endtask

  // one rise; cam_ready checked just before and just after the FSM consumes the edge
  task automatic edge_check(input int period, input logic rdy_before, input logic rdy_after,
                            input string tag);
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cam_ready !== rdy_before) begin
      errors++;
      $display("FAIL %s_before: cam_ready=%b expected %b", tag, cam_ready, rdy_before);
    end
    @(negedge clk);
    checks++;
    if (cam_ready !== rdy_after) begin
      errors++;
      $display("FAIL %s_after: cam_ready=%b expected %b", tag, cam_ready, rdy_after);
    end
    cam_vsync = 1'b0;
    repeat (period - 5) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cam_ready, cam_rst_req, cam_fail, frame_period, retry_cnt, state_o} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {cam_ready, cam_rst_req, cam_fail, frame_period, retry_cnt, state_o});
    end
    resetn = 1'b1;
    base   = cyc;
    repeat (5) @(negedge clk);
    checks++;
    if ({cam_ready, cam_rst_req, cam_fail, frame_period, retry_cnt, state_o} !== 31'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected 0",
               {cam_ready, cam_rst_req, cam_fail, frame_period, retry_cnt, state_o});
    end
  endtask

  task automatic test_steady_vsync();
    int r0;
    do_reset();
    r0 = req_cycles.size();
    vsync_frames(5, 200);
    edge_check(200, 1'b0, 1'b1, "t1_ready_edge6");
    checks++;
    if (frame_period !== 24'd200) begin
      errors++;
      $display("FAIL t1_frame_period: got %0d expected 200", frame_period);
    end
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL t1_state: got %0d expected 2", state_o);
    end
    checks++;
    if (req_cycles.size() - r0 != 0) begin
      errors++;
      $display("FAIL t1_no_rst_req: got %0d pulses expected 0", req_cycles.size() - r0);
    end
  endtask

  task automatic test_tolerance_restart();
    do_reset();
    vsync_frames(2, 200);
    vsync_frames(1, 210);
    vsync_frames(5, 200);
    checks++;
    if (cam_ready !== 1'b0 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL t2_not_ready_yet: ready=%b state=%0d expected ready=0 state=1",
               cam_ready, state_o);
    end
    edge_check(200, 1'b0, 1'b1, "t2_ready_after_restart");
    checks++;
    if (frame_period !== 24'd200) begin
      errors++;
      $display("FAIL t2_frame_period: got %0d expected 200", frame_period);
    end
  endtask

  task automatic test_no_vsync();
    int r0;
    do_reset();
    r0 = req_cycles.size();
    repeat (4100) @(negedge clk);
    checks++;
    if (req_cycles.size() - r0 != 3) begin
      errors++;
      $display("FAIL t3_req_count: got %0d expected 3", req_cycles.size() - r0);
    end else begin
      checks++;
      if (req_cycles[r0] - base != 1001 || req_cycles[r0+1] - base != 2003 ||
          req_cycles[r0+2] - base != 3005) begin
        errors++;
        $display("FAIL t3_req_times: got %0d %0d %0d expected 1001 2003 3005",
                 req_cycles[r0] - base, req_cycles[r0+1] - base, req_cycles[r0+2] - base);
      end
    end
    checks++;
    if (retry_cnt !== 2'd3 || cam_fail !== 1'b1 || state_o !== 3'd4 || cam_ready !== 1'b0) begin
      errors++;
      $display("FAIL t3_fail_state: retry=%0d fail=%b state=%0d ready=%b expected 3 1 4 0",
               retry_cnt, cam_fail, state_o, cam_ready);
    end
    vsync_frames(6, 200);
    checks++;
    if (cam_fail !== 1'b1 || state_o !== 3'd4 || cam_ready !== 1'b0 ||
        req_cycles.size() - r0 != 3) begin
      errors++;
      $display("FAIL t3_fail_sticky: fail=%b state=%0d ready=%b reqs=%0d expected 1 4 0 3",
               cam_fail, state_o, cam_ready, req_cycles.size() - r0);
    end
  endtask

  task automatic test_ready_then_silence();
    int r0;
    int rise;
    do_reset();
    r0 = req_cycles.size();
    vsync_frames(6, 200);
    @(negedge clk);
    cam_vsync = 1'b1;
    rise = cyc;
    repeat (4) @(negedge clk);
    cam_vsync = 1'b0;
    while (cyc < rise + 1004) @(negedge clk);
    checks++;
    if (cam_ready !== 1'b1 || cam_rst_req !== 1'b0 || frame_period !== 24'd200) begin
      errors++;
      $display("FAIL t4_before_timeout: ready=%b req=%b period=%0d expected 1 0 200",
               cam_ready, cam_rst_req, frame_period);
    end
    @(negedge clk);
    checks++;
    if (cam_ready !== 1'b0 || cam_rst_req !== 1'b1 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL t4_timeout: ready=%b req=%b state=%0d expected 0 1 3",
               cam_ready, cam_rst_req, state_o);
    end
    @(negedge clk);
    checks++;
    if (retry_cnt !== 2'd1 || state_o !== 3'd0 || cam_rst_req !== 1'b0) begin
      errors++;
      $display("FAIL t4_after_retry: retry=%0d state=%0d req=%b expected 1 0 0",
               retry_cnt, state_o, cam_rst_req);
    end
    vsync_frames(5, 200);
    edge_check(200, 1'b0, 1'b1, "t4_recover");
    checks++;
    if (retry_cnt !== 2'd1 || req_cycles.size() - r0 != 1) begin
      errors++;
      $display("FAIL t4_retry_kept: retry=%0d reqs=%0d expected 1 1",
               retry_cnt, req_cycles.size() - r0);
    end
  endtask

  task automatic test_period_glitch();
    int r0;
    do_reset();
    r0 = req_cycles.size();
    vsync_frames(5, 200);
    vsync_frames(1, 260);
    edge_check(200, 1'b1, 1'b0, "t5_drop_260");
    checks++;
    if (frame_period !== 24'd200 || state_o !== 3'd1) begin
      errors++;
      $display("FAIL t5_after_drop: period=%0d state=%0d expected 200 1", frame_period, state_o);
    end
    vsync_frames(4, 200);
    edge_check(204, 1'b0, 1'b1, "t5_regain");
    edge_check(209, 1'b1, 1'b1, "t5_tol_edge_in");
    checks++;
    if (frame_period !== 24'd204) begin
      errors++;
      $display("FAIL t5_period_204: got %0d expected 204", frame_period);
    end
    edge_check(200, 1'b1, 1'b0, "t5_tol_edge_out");
    checks++;
    if (frame_period !== 24'd204 || req_cycles.size() - r0 != 0) begin
      errors++;
      $display("FAIL t5_final: period=%0d reqs=%0d expected 204 0",
               frame_period, req_cycles.size() - r0);
    end
  endtask

  task automatic test_midway_reset();
    int r0;
    bit seen;
    do_reset();
    r0 = req_cycles.size();
    vsync_frames(1, 1001);
    vsync_frames(1, 200);
    checks++;
    if (state_o !== 3'd1 || retry_cnt !== 2'd0 || req_cycles.size() - r0 != 0) begin
      errors++;
      $display("FAIL t6_edge_on_timeout: state=%0d retry=%0d reqs=%0d expected 1 0 0",
               state_o, retry_cnt, req_cycles.size() - r0);
    end
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({cam_ready, cam_rst_req, cam_fail, frame_period, retry_cnt, state_o} !== 31'd0) begin
      errors++;
      $display("FAIL t6_async_reset_measure: got %h expected 0",
               {cam_ready, cam_rst_req, cam_fail, frame_period, retry_cnt, state_o});
    end
    @(negedge clk);
    resetn = 1'b1;
    base   = cyc;
    seen   = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge clk);
      if (cam_rst_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL t6_wait_req: cam_rst_req=0 after 1100 clks expected a pulse");
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (cam_rst_req !== 1'b0 || state_o !== 3'd0 || retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL t6_reset_drops_req: req=%b state=%0d retry=%0d expected 0 0 0",
               cam_rst_req, state_o, retry_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (retry_cnt !== 2'd0 || state_o !== 3'd0 || cam_rst_req !== 1'b0) begin
      errors++;
      $display("FAIL t6_after_release: retry=%0d state=%0d req=%b expected 0 0 0",
               retry_cnt, state_o, cam_rst_req);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    cam_vsync = 1'b0;
    test_reset();
    test_steady_vsync();
    test_tolerance_restart();
    test_no_vsync();
    test_ready_then_silence();
    test_period_glitch();
    test_midway_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
